// File: rtl/dense_fc_pkg.sv
// Shared types and helpers for the dense fully-connected layer blocks.
//
// Contents:
//   act_t        signed 8-bit activation / weight / zero-point type
//   acc_t        signed 32-bit accumulator type
//   qmult_t      signed Q31 requantisation multiplier
//   state_t      neuron sequencer states
//   Q_FRAC       fractional bits of the Q31 multiplier
//   requant_clamp  acc -> int8 requantisation with round-half-up and saturation
package dense_fc_pkg;

    typedef logic signed [7:0]  act_t;
    typedef logic signed [31:0] acc_t;
    typedef logic signed [31:0] qmult_t;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        REQ,
        OUT,
        DONE
    } state_t;

    localparam int Q_FRAC = 31;

    // Scales the accumulator by a Q31 multiplier plus an extra right shift,
    // rounding half up, then adds the output zero point and saturates to int8.
    // The full 64-bit product is kept so no precision is lost before rounding;
    // the worst case |p| + rounding constant stays below 2^63.
    function automatic act_t requant_clamp(input acc_t acc, input qmult_t qmult,
                                           input logic [4:0] qshift, input act_t out_zp);
        logic signed [63:0] a64;
        logic signed [63:0] q64;
        logic signed [63:0] p;
        logic signed [63:0] rnd;
        logic signed [63:0] r;
        logic signed [63:0] zp64;
        logic signed [63:0] y;
        logic [5:0]         s;
        act_t               res;
        a64  = {{32{acc[31]}}, acc};
        q64  = {{32{qmult[31]}}, qmult};
        zp64 = {{56{out_zp[7]}}, out_zp};
        s    = 6'(Q_FRAC) + {1'b0, qshift};
        p    = a64 * q64;
        rnd  = 64'sd1 <<< (s - 6'd1);
        r    = (p + rnd) >>> s;
        y    = r + zp64;
        if (y > 64'sd127) begin
            res = 8'sd127;
        end else if (y < -64'sd128) begin
            res = -8'sd128;
        end else begin
            res = y[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/dense_fc_requant.sv
// Combinational int32 -> int8 requantiser, shared by the FC layer sequencers.
//
// Ports:
//   i_acc     signed 32-bit accumulator
//   i_qmult   signed Q31 multiplier
//   i_qshift  extra right shift 0..31
//   i_out_zp  signed output zero point
//   o_data    saturated signed int8 result
module dense_fc_requant
    import dense_fc_pkg::*;
(
    input  acc_t       i_acc,
    input  qmult_t     i_qmult,
    input  logic [4:0] i_qshift,
    input  act_t       i_out_zp,
    output act_t       o_data
);

    assign o_data = requant_clamp(i_acc, i_qmult, i_qshift, i_out_zp);

endmodule

// File: rtl/dense_fc_neuron_seq.sv
// Sequencer + MAC datapath for one dense FC layer. Reads the int8 activation
// vector out of the FC RAM once per output neuron, multiplies it against the
// weight ROM row for that neuron, adds the bias, requantises to int8 and
// hands each result out on a valid/ready stream.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-low reset
//   i_start             start pulse, only honoured in IDLE
//   i_in_zp, i_out_zp   input / output zero points (captured on start)
//   i_qmult, i_qshift   requantisation multiplier and shift (captured on start)
//   o_act_addr/o_act_re FC RAM read port, i_act_data returns 1 cycle later
//   o_w_addr/i_w_data   weight ROM, address o*N_IN+i, data 1 cycle later
//   o_b_addr/i_b_data   bias ROM, address o, data 1 cycle later
//   o_out_data/o_out_idx/o_out_valid/i_out_ready  result stream
//   o_busy              high whenever not IDLE
//   o_done              one-cycle pulse after the last neuron is accepted
module dense_fc_neuron_seq
    import dense_fc_pkg::*;
#(
    parameter int N_IN      = 64,
    parameter int N_OUT     = 10,
    parameter int RAM_DEPTH = 256,
    parameter int W_ADDR_W  = $clog2(N_IN * N_OUT),
    localparam int A_W      = $clog2(RAM_DEPTH),
    localparam int O_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic signed [7:0]   i_in_zp,
    input  logic signed [7:0]   i_out_zp,
    input  logic signed [31:0]  i_qmult,
    input  logic [4:0]          i_qshift,
    output logic [A_W-1:0]      o_act_addr,
    output logic                o_act_re,
    input  logic signed [7:0]   i_act_data,
    output logic [W_ADDR_W-1:0] o_w_addr,
    input  logic signed [7:0]   i_w_data,
    output logic [O_W-1:0]      o_b_addr,
    input  logic signed [31:0]  i_b_data,
    output logic signed [7:0]   o_out_data,
    output logic [O_W-1:0]      o_out_idx,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic                o_busy,
    output logic                o_done
);

    state_t              r_state;
    logic [A_W-1:0]      r_i;
    logic [O_W-1:0]      r_o;
    acc_t                r_acc;
    logic                r_vld;
    logic                r_first;
    act_t                r_in_zp;
    act_t                r_out_zp;
    qmult_t              r_qmult;
    logic [4:0]          r_qshift;
    logic [A_W-1:0]      r_act_addr;
    logic                r_act_re;
    logic [W_ADDR_W-1:0] r_w_addr;
    logic [O_W-1:0]      r_b_addr;
    act_t                r_out_data;
    logic [O_W-1:0]      r_out_idx;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;

    logic [8:0]          w_diff;
    logic [16:0]         w_diff17;
    logic [16:0]         w_wt17;
    logic [16:0]         w_prod;
    logic [31:0]         w_prod32;
    act_t                w_req;

    // The 9-bit difference and 17-bit product are formed with explicit sign
    // extension so the arithmetic is exact modulo 2^32; the accumulator
    // deliberately wraps on overflow.
    assign w_diff   = {i_act_data[7], i_act_data} - {r_in_zp[7], r_in_zp};
    assign w_diff17 = {{8{w_diff[8]}}, w_diff};
    assign w_wt17   = {{9{i_w_data[7]}}, i_w_data};
    assign w_prod   = w_diff17 * w_wt17;
    assign w_prod32 = {{15{w_prod[16]}}, w_prod};

    dense_fc_requant u_requant (
        .i_acc    (r_acc),
        .i_qmult  (r_qmult),
        .i_qshift (r_qshift),
        .i_out_zp (r_out_zp),
        .o_data   (w_req)
    );

    // Single FSM block. Read-port outputs are registered so they line up with
    // the state: each MAC cycle presents the address of element r_i. Returning
    // data is qualified by r_vld (act_re delayed one cycle); r_first marks the
    // element-0 return, where the bias replaces the old accumulator value.
    // The accumulate statement sits before the case so the clear on the
    // OUT -> MAC transition is not overridden (r_vld is low there anyway).
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_o         <= '0;
            r_acc       <= '0;
            r_vld       <= 1'b0;
            r_first     <= 1'b0;
            r_in_zp     <= '0;
            r_out_zp    <= '0;
            r_qmult     <= '0;
            r_qshift    <= '0;
            r_act_addr  <= '0;
            r_act_re    <= 1'b0;
            r_w_addr    <= '0;
            r_b_addr    <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vld   <= r_act_re;
            r_first <= r_act_re && (r_act_addr == '0);
            if (r_vld) begin
                if (r_first) begin
                    r_acc <= i_b_data + w_prod32;
                end else begin
                    r_acc <= r_acc + w_prod32;
                end
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_in_zp    <= i_in_zp;
                        r_out_zp   <= i_out_zp;
                        r_qmult    <= i_qmult;
                        r_qshift   <= i_qshift;
                        r_o        <= '0;
                        r_i        <= '0;
                        r_acc      <= '0;
                        r_act_re   <= 1'b1;
                        r_act_addr <= '0;
                        r_w_addr   <= '0;
                        r_b_addr   <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= MAC;
                    end
                end
                MAC: begin
                    if (r_i == A_W'(N_IN - 1)) begin
                        r_act_re <= 1'b0;
                        r_state  <= DRAIN;
                    end else begin
                        r_i        <= r_i + 1'b1;
                        r_act_addr <= r_i + 1'b1;
                        r_w_addr   <= r_w_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    r_state <= REQ;
                end
                REQ: begin
                    r_out_data  <= w_req;
                    r_out_idx   <= r_o;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_o == O_W'(N_OUT - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            // Weight addresses are contiguous across neurons,
                            // so the next row starts one past the last issue.
                            r_o        <= r_o + 1'b1;
                            r_i        <= '0;
                            r_acc      <= '0;
                            r_act_re   <= 1'b1;
                            r_act_addr <= '0;
                            r_w_addr   <= r_w_addr + 1'b1;
                            r_b_addr   <= r_o + 1'b1;
                            r_state    <= MAC;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_act_addr  = r_act_addr;
    assign o_act_re    = r_act_re;
    assign o_w_addr    = r_w_addr;
    assign o_b_addr    = r_b_addr;
    assign o_out_data  = r_out_data;
    assign o_out_idx   = r_out_idx;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_dense_fc_neuron_seq.sv
// Testbench for dense_fc_neuron_seq: directed scenarios plus randomised
// layers, checked against an arithmetic model of the neuron computation.
module tb_dense_fc_neuron_seq;

    localparam int N_IN      = 4;
    localparam int N_OUT     = 3;
    localparam int RAM_DEPTH = 16;
    localparam int W_ADDR_W  = $clog2(N_IN * N_OUT);
    localparam int A_W       = $clog2(RAM_DEPTH);
    localparam int O_W       = $clog2(N_OUT);

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic signed [7:0]   inZp;
    logic signed [7:0]   outZp;
    logic signed [31:0]  qmult;
    logic [4:0]          qshift;
    logic [A_W-1:0]      actAddr;
    logic                actRe;
    logic signed [7:0]   actData;
    logic [W_ADDR_W-1:0] wAddr;
    logic signed [7:0]   wData;
    logic [O_W-1:0]      bAddr;
    logic signed [31:0]  bData;
    logic signed [7:0]   outData;
    logic [O_W-1:0]      outIdx;
    logic                outValid;
    logic                outReady;
    logic                busy;
    logic                done;

    byte          actMem[RAM_DEPTH];
    byte          wMem[16];
    int           bMem[4];
    byte          cfgInZp;
    byte          cfgOutZp;
    int           cfgQmult;
    logic [4:0]   cfgQshift;
    byte          lastOut[N_OUT];
    int           checks = 0;
    int           errors = 0;
    int           cyc;

    always #5 clk = ~clk;

    dense_fc_neuron_seq #(
        .N_IN      (N_IN),
        .N_OUT     (N_OUT),
        .RAM_DEPTH (RAM_DEPTH),
        .W_ADDR_W  (W_ADDR_W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_in_zp     (inZp),
        .i_out_zp    (outZp),
        .i_qmult     (qmult),
        .i_qshift    (qshift),
        .o_act_addr  (actAddr),
        .o_act_re    (actRe),
        .i_act_data  (actData),
        .o_w_addr    (wAddr),
        .i_w_data    (wData),
        .o_b_addr    (bAddr),
        .i_b_data    (bData),
        .o_out_data  (outData),
        .o_out_idx   (outIdx),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Memory models with one cycle of read latency.
    always @(posedge clk) begin
        if (actRe) actData <= actMem[actAddr];
        wData <= wMem[wAddr];
        bData <= bMem[bAddr];
    end

    // Watchdog so a wedged design still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: exact dot product wrapped to 32 bits, then scaling by
    // qmult / 2^(31+qshift) with floor(x + 1/2) rounding and saturation.
    function automatic byte refNeuron(input int o);
        longint sum;
        int     acc;
        longint p;
        longint d;
        longint num;
        longint q;
        longint y;
        int     s;
        sum = bMem[o];
        for (int i = 0; i < N_IN; i++) begin
            sum += (longint'(actMem[i]) - longint'(cfgInZp)) * longint'(wMem[o * N_IN + i]);
        end
        acc = int'(sum);
        p   = longint'(acc) * longint'(cfgQmult);
        s   = 31 + int'(cfgQshift);
        d   = longint'(1) <<< s;
        num = p + d / 2;
        q   = num / d;
        if ((num % d) != 0 && num < 0) q = q - 1;
        y = q + longint'(cfgOutZp);
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return byte'(y);
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulses start with the given configuration, then scrambles the pins to
    // show the captured copies are what the design uses.
    task automatic applyStimulus(input byte iz, input byte oz, input int qm, input logic [4:0] qs);
        cfgInZp   = iz;
        cfgOutZp  = oz;
        cfgQmult  = qm;
        cfgQshift = qs;
        inZp      = iz;
        outZp     = oz;
        qmult     = qm;
        qshift    = qs;
        start     = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        inZp   = 8'($urandom);
        outZp  = 8'($urandom);
        qmult  = 32'($urandom);
        qshift = 5'($urandom);
        cyc    = 1;
    endtask

    // Walks one whole layer: checks the read sequence, the results, stalls
    // with out_ready low and the done pulse. Optionally checks cycle timing
    // and pokes start while busy.
    task automatic runLayer(input int stall, input bit chkLat, input bit poke);
        int n;
        checkOutput("busy_after_start", busy, 1);
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                checkOutput("act_re", actRe, 1);
                checkOutput("act_addr", actAddr, i);
                checkOutput("w_addr", wAddr, o * N_IN + i);
                checkOutput("b_addr", bAddr, o);
                start = (poke && o == 1 && i == 0);
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            checkOutput("drain_re", actRe, 0);
            n = 0;
            while (!outValid && n < 20) begin
                @(negedge clk);
                cyc++;
                n++;
            end
            checkOutput("out_valid", outValid, 1);
            if (chkLat) checkOutput("latency_valid", cyc, o * (N_IN + 3) + N_IN + 3);
            for (int k = 0; k < stall; k++) begin
                checkOutput("stall_data", outData, refNeuron(o));
                checkOutput("stall_idx", outIdx, o);
                checkOutput("stall_valid", outValid, 1);
                checkOutput("stall_done", done, 0);
                @(negedge clk);
                cyc++;
            end
            checkOutput("out_data", outData, refNeuron(o));
            checkOutput("out_idx", outIdx, o);
            lastOut[o] = outData;
            outReady = 1'b1;
            @(negedge clk);
            cyc++;
            outReady = 1'b0;
        end
        checkOutput("done_pulse", done, 1);
        if (chkLat) checkOutput("latency_done", cyc, N_OUT * (N_IN + 3) + 1);
        @(negedge clk);
        checkOutput("done_clear", done, 0);
        checkOutput("busy_clear", busy, 0);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < RAM_DEPTH; i++) actMem[i] = byte'($urandom);
        for (int i = 0; i < 16; i++) wMem[i] = byte'($urandom);
        for (int o = 0; o < 4; o++) bMem[o] = int'($urandom_range(0, 40000)) - 20000;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_act_re"}, actRe, 0);
        checkOutput({tag, "_act_addr"}, actAddr, 0);
        checkOutput({tag, "_w_addr"}, wAddr, 0);
        checkOutput({tag, "_b_addr"}, bAddr, 0);
        checkOutput({tag, "_out_data"}, outData, 0);
        checkOutput({tag, "_out_idx"}, outIdx, 0);
        checkOutput({tag, "_out_valid"}, outValid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        outReady = 1'b0;
        inZp     = '0;
        outZp    = '0;
        qmult    = '0;
        qshift   = '0;
        fillRandom();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b1;
        @(negedge clk);

        // Directed: 1+2+3+4 = 10, scaled by 0.5 -> 5.
        $display("[TB] directed basic");
        for (int i = 0; i < N_IN; i++) begin
            actMem[i] = byte'(i + 1);
            wMem[i]   = 8'sd1;
        end
        bMem[0] = 0;
        applyStimulus(8'sd0, 8'sd0, 32'h4000_0000, 5'd0);
        runLayer(0, 1'b1, 1'b0);
        checkOutput("dirA_out", lastOut[0], 5);

        // Directed: zero points and bias: (0+1+2+3) - 2 = 4 -> 2 - 3 = -1.
        $display("[TB] directed zero points");
        bMem[0] = -2;
        applyStimulus(8'sd1, -8'sd3, 32'h4000_0000, 5'd0);
        runLayer(0, 1'b1, 1'b0);
        checkOutput("dirB_out", lastOut[0], -1);

        // Saturation in both directions.
        $display("[TB] directed saturation");
        for (int i = 0; i < N_IN; i++) actMem[i] = 8'sd127;
        for (int i = 0; i < N_IN * N_OUT; i++) wMem[i] = 8'sd127;
        for (int o = 0; o < N_OUT; o++) bMem[o] = 0;
        applyStimulus(8'sd0, 8'sd0, 32'h7FFF_FFFF, 5'd0);
        runLayer(0, 1'b1, 1'b0);
        checkOutput("sat_hi", lastOut[0], 127);
        for (int i = 0; i < N_IN * N_OUT; i++) wMem[i] = -8'sd127;
        applyStimulus(8'sd0, 8'sd0, 32'h7FFF_FFFF, 5'd0);
        runLayer(0, 1'b1, 1'b0);
        checkOutput("sat_lo", lastOut[0], -128);

        // Backpressure with a start poke while busy.
        $display("[TB] backpressure");
        fillRandom();
        applyStimulus(byte'($urandom), byte'($urandom), int'($urandom) >>> 8, 5'd1);
        runLayer(5, 1'b0, 1'b1);

        // Randomised layers.
        $display("[TB] random layers");
        for (int t = 0; t < 8; t++) begin
            fillRandom();
            applyStimulus(byte'($urandom), byte'($urandom),
                          int'($urandom) >>> $urandom_range(4, 16), 5'($urandom_range(0, 6)));
            runLayer(t % 3, (t % 3) == 0, t[0]);
        end

        // Abort during neuron 1, then a clean restart.
        $display("[TB] abort and restart");
        fillRandom();
        outReady = 1'b1;
        applyStimulus(byte'($urandom), byte'($urandom), int'($urandom) >>> 10, 5'd2);
        repeat (N_IN + 3 + 2) @(negedge clk);
        checkOutput("abort_pre_busy", busy, 1);
        checkOutput("abort_pre_re", actRe, 1);
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("abort");
        reset    = 1'b1;
        outReady = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("abort_no_done", done, 0);
            checkOutput("abort_idle", busy, 0);
        end
        applyStimulus(byte'($urandom), byte'($urandom), int'($urandom) >>> 12, 5'd0);
        runLayer(0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
